multi_cycle_control_unit: RTL and testbench
===========================================

MULTI_CYCLE_CONTROL_UNIT -- requirements
Module: multi_cycle_control_unit

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, maximum wait cycles in a memory state; used only with CU_MEM_WAIT_EN.
REQ-002 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port instrCode, input, 32, instruction-register output; stable from DECODE until retire.
REQ-005 SHALL have port dataReady, input, 1, memory access complete.
REQ-006 SHALL have port pcEn, output, 1, PC load strobe.
REQ-007 SHALL have port irWe, output, 1, instruction-register write.
REQ-008 SHALL have port regFileWe, output, 1, register-file write.
REQ-009 SHALL have port aluControl, output, 4, ALU operation, encoded {func7[5], func3}.
REQ-010 SHALL have port aluSrcMuxSel, output, 1, ALU B operand select: 0 = rs2, 1 = immediate.
REQ-011 SHALL have port wbSrcMuxSel, output, 1, write-back select: 0 = ALU, 1 = data memory.
REQ-012 SHALL have port dataWe, output, 1, data-memory write.
REQ-013 SHALL have port dataRe, output, 1, data-memory read.
REQ-014 SHALL have port instrRetire, output, 1, one-cycle pulse in the final state of each instruction.
REQ-015 SHALL have port illegalInstr, output, 1, one-cycle pulse on an unsupported opcode.
REQ-016 SHALL have port busErr, output, 1, one-cycle pulse on memory timeout; constant 0 without CU_MEM_WAIT_EN.

Function
REQ-017 SHALL implement FSM states FETCH, DECODE, EXE, MEM, WB; all outputs are Moore-decoded from the state and the instrCode opcode.
REQ-018 SHALL assert irWe=1 and pcEn=1 in FETCH only, then move to DECODE unconditionally.
REQ-019 SHALL go from DECODE to EXE for opcodes R (0110011), I (0010011), S (0100011) and L (0000011).
REQ-020 SHALL, on any other opcode in DECODE, pulse illegalInstr, assert no write enable, and return to FETCH.
REQ-021 SHALL retire R-type in EXE: regFileWe=1, aluSrcMuxSel=0, aluControl={instr[30], func3}; 3 cycles total.
REQ-022 SHALL retire I-type in EXE: regFileWe=1, aluSrcMuxSel=1, aluControl={instr[30] if func3=101 else 0, func3}; 3 cycles total.
REQ-023 SHALL run S-type as EXE (aluSrcMuxSel=1, aluControl=ADD 0000), then MEM (dataWe=1, retire); 4 cycles total.
REQ-024 SHALL run L-type as EXE (aluSrcMuxSel=1, ADD), then MEM (dataRe=1), then WB (regFileWe=1, wbSrcMuxSel=1, retire); 5 cycles total.
REQ-025 SHALL drive aluControl=0000 in FETCH and DECODE, and every unused enable or select to 0 in every state.
REQ-026 SHALL never assert regFileWe and dataWe in the same cycle.

Reset
REQ-027 SHALL, while reset=1, hold every output at 0 and load state FETCH; the first cycle after release is FETCH.
REQ-028 SHALL, on reset asserted mid-instruction, abandon it on the next edge with no further write or retire pulse.
REQ-029 SHALL clear the timeout counter on reset.

Configuration
REQ-030 SHALL, with CU_MEM_WAIT_EN defined, hold MEM until dataReady=1 and keep dataWe/dataRe asserted throughout; the exit cycle is the cycle in which dataReady=1.
REQ-031 SHALL, with CU_MEM_WAIT_EN defined, count MEM cycles and, if dataReady=0 for MEM_TIMEOUT consecutive cycles, pulse busErr, drop the access, skip WB and retire, and return to FETCH.
REQ-032 SHALL, without CU_MEM_WAIT_EN, make MEM exactly one cycle, ignore dataReady, omit the counter, and tie busErr to 0.

Structure
REQ-033 SHALL take the opcode constants (OP_TYPE_R/I/S/L), the ALU encodings (ADD etc.) and the state enum typedef from a shared package cpu_pkg.
REQ-034 SHALL use one sub-module, mem_wait_timer (counter plus timeout compare), instantiated only under CU_MEM_WAIT_EN.

Verification
REQ-035 SHALL test R-type: ADD 0x00208033 -> FETCH, DECODE, EXE; regFileWe=1 and aluControl=0000 in cycle 3; instrRetire in cycle 3.
REQ-036 SHALL test R-type SUB: 0x40208033 -> aluControl=1000; I-type SRAI 0x4030D093 -> aluControl=1101 with aluSrcMuxSel=1.
REQ-037 SHALL test S-type: SW 0x0020A023 -> dataWe=1 only in cycle 4; regFileWe stays 0 throughout.
REQ-038 SHALL test L-type: LW 0x0000A083 with dataReady held low 3 cycles under CU_MEM_WAIT_EN -> MEM lasts 4 cycles; WB has regFileWe=1 and wbSrcMuxSel=1.
REQ-039 SHALL test timeout: dataReady stuck 0 with MEM_TIMEOUT=15 -> busErr pulse after 15 MEM cycles, no regFileWe, next state FETCH.
REQ-040 SHALL test error and reset: opcode 1111111 -> illegalInstr pulse in DECODE, then FETCH; reset asserted during L-type MEM -> all outputs 0 and FETCH after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle control unit: FSM states, opcodes, ALU codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXE    = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_t;

    // Supported major opcodes (instr[6:0])
    localparam logic [6:0] OP_TYPE_R = 7'b0110011;
    localparam logic [6:0] OP_TYPE_I = 7'b0010011;
    localparam logic [6:0] OP_TYPE_S = 7'b0100011;
    localparam logic [6:0] OP_TYPE_L = 7'b0000011;

    // ALU operation encodings, {func7[5], func3}
    localparam logic [3:0] ADD  = 4'b0000;
    localparam logic [3:0] SUB  = 4'b1000;
    localparam logic [3:0] SLL  = 4'b0001;
    localparam logic [3:0] SLT  = 4'b0010;
    localparam logic [3:0] SLTU = 4'b0011;
    localparam logic [3:0] XOR  = 4'b0100;
    localparam logic [3:0] SRL  = 4'b0101;
    localparam logic [3:0] SRA  = 4'b1101;
    localparam logic [3:0] OR   = 4'b0110;
    localparam logic [3:0] AND  = 4'b0111;

    function automatic logic op_supported(input logic [6:0] op);
        return (op == OP_TYPE_R) || (op == OP_TYPE_I) ||
               (op == OP_TYPE_S) || (op == OP_TYPE_L);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags a timeout.
// Latency: timeout is combinational in the TIMEOUT-th consecutive not-ready cycle.
// Backpressure: none; counter clears whenever the access is inactive, completes or times out.
// Ports: clk, reset (sync, active-high), active (access in progress), ready (access done),
//        timeout (asserted in the last allowed not-ready cycle).
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic ready,
    output logic timeout
);

    localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // cnt holds the number of not-ready cycles already spent before the current one
    logic [W-1:0] cnt;

    assign timeout = active && !ready && (cnt == W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset || !active || ready || timeout) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32 control unit: FETCH/DECODE/EXE/MEM/WB sequencing for R, I, S, L opcodes.
// Latency: R/I retire in cycle 3, S in cycle 4, L in cycle 5 (MEM may stretch with CU_MEM_WAIT_EN).
// Backpressure: with CU_MEM_WAIT_EN, MEM holds until dataReady or MEM_TIMEOUT (busErr); else none.
// Ports: clk, reset (sync, active-high), instrCode (IR contents), dataReady (memory done);
//        outputs pcEn, irWe, regFileWe, aluControl, aluSrcMuxSel, wbSrcMuxSel, dataWe, dataRe,
//        instrRetire, illegalInstr, busErr. Optional feature macro: CU_MEM_WAIT_EN.
module multi_cycle_control_unit
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrCode,
    input  logic        dataReady,
    output logic        pcEn,
    output logic        irWe,
    output logic        regFileWe,
    output logic [3:0]  aluControl,
    output logic        aluSrcMuxSel,
    output logic        wbSrcMuxSel,
    output logic        dataWe,
    output logic        dataRe,
    output logic        instrRetire,
    output logic        illegalInstr,
    output logic        busErr
);

    state_t     state;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       func7b5;
    logic       is_r, is_i, is_s, is_l;
    logic       in_mem;
    logic       mem_done;     // access completes this cycle
    logic       mem_timeout;  // access abandoned this cycle

    assign opcode  = instrCode[6:0];
    assign func3   = instrCode[14:12];
    assign func7b5 = instrCode[30];
    assign is_r    = (opcode == OP_TYPE_R);
    assign is_i    = (opcode == OP_TYPE_I);
    assign is_s    = (opcode == OP_TYPE_S);
    assign is_l    = (opcode == OP_TYPE_L);
    assign in_mem  = (state == MEM);

`ifdef CU_MEM_WAIT_EN
    mem_wait_timer #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .active  (in_mem),
        .ready   (dataReady),
        .timeout (mem_timeout)
    );
    assign mem_done = dataReady;

    logic unused_instr_bits;
    assign unused_instr_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};
`else
    // Single-cycle MEM: the handshake input and timeout parameter have no effect.
    assign mem_timeout = 1'b0;
    assign mem_done    = 1'b1;

    localparam int unsigned unused_mem_timeout = MEM_TIMEOUT;
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instrCode[31], instrCode[29:15], instrCode[11:7], dataReady};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            case (state)
                FETCH:   state <= DECODE;
                DECODE:  state <= op_supported(opcode) ? EXE : FETCH;
                EXE:     state <= (is_s || is_l) ? MEM : FETCH;
                MEM: begin
                    if (mem_done) begin
                        state <= is_l ? WB : FETCH;
                    end else if (mem_timeout) begin
                        state <= FETCH;
                    end
                end
                WB:      state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    // Moore output decode from state and opcode; reset forces everything low
    // so an abandoned instruction cannot emit a write or retire on its way out.
    always_comb begin
        pcEn         = 1'b0;
        irWe         = 1'b0;
        regFileWe    = 1'b0;
        aluControl   = ADD;
        aluSrcMuxSel = 1'b0;
        wbSrcMuxSel  = 1'b0;
        dataWe       = 1'b0;
        dataRe       = 1'b0;
        instrRetire  = 1'b0;
        illegalInstr = 1'b0;
        busErr       = 1'b0;
        if (!reset) begin
            case (state)
                FETCH: begin
                    pcEn = 1'b1;
                    irWe = 1'b1;
                end
                DECODE: begin
                    illegalInstr = !op_supported(opcode);
                end
                EXE: begin
                    if (is_r) begin
                        regFileWe   = 1'b1;
                        aluControl  = {func7b5, func3};
                        instrRetire = 1'b1;
                    end else if (is_i) begin
                        regFileWe    = 1'b1;
                        aluSrcMuxSel = 1'b1;
                        // instr[30] is immediate data except for shift-right
                        aluControl   = {(func3 == 3'b101) ? func7b5 : 1'b0, func3};
                        instrRetire  = 1'b1;
                    end else if (is_s || is_l) begin
                        aluSrcMuxSel = 1'b1;
                        aluControl   = ADD;
                    end
                end
                MEM: begin
                    dataWe      = is_s;
                    dataRe      = is_l;
                    instrRetire = is_s && mem_done;
                    busErr      = mem_timeout;
                end
                WB: begin
                    regFileWe   = is_l;
                    wbSrcMuxSel = is_l;
                    instrRetire = is_l;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
module tb_multi_cycle_control_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instrCode = 32'h0;
    logic        dataReady = 1'b1;
    logic        pcEn, irWe, regFileWe, aluSrcMuxSel, wbSrcMuxSel;
    logic        dataWe, dataRe, instrRetire, illegalInstr, busErr;
    logic [3:0]  aluControl;

    always #5 clk = ~clk;

    multi_cycle_control_unit #(.MEM_TIMEOUT(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .instrCode    (instrCode),
        .dataReady    (dataReady),
        .pcEn         (pcEn),
        .irWe         (irWe),
        .regFileWe    (regFileWe),
        .aluControl   (aluControl),
        .aluSrcMuxSel (aluSrcMuxSel),
        .wbSrcMuxSel  (wbSrcMuxSel),
        .dataWe       (dataWe),
        .dataRe       (dataRe),
        .instrRetire  (instrRetire),
        .illegalInstr (illegalInstr),
        .busErr       (busErr)
    );

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic        rdy;
        logic [13:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   n_applied = 0;
    int   n_miscompares = 0;

    localparam logic [31:0] I_ADD  = 32'h00208033;
    localparam logic [31:0] I_SUB  = 32'h40208033;
    localparam logic [31:0] I_SRAI = 32'h4030D093;
    localparam logic [31:0] I_ADDI = 32'h40000093;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_LW   = 32'h0000A083;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

    function automatic logic [13:0] o(input logic pc, input logic ir, input logic rf,
                                      input logic [3:0] alu, input logic asrc, input logic wb,
                                      input logic dwe, input logic dre, input logic ret,
                                      input logic ill, input logic be);
        return {pc, ir, rf, alu, asrc, wb, dwe, dre, ret, ill, be};
    endfunction

    localparam logic [13:0] OZ = 14'b0;
    localparam logic [13:0] OF = 14'b11_0_0000_0000000;

    task automatic add(input logic r, input logic [31:0] i, input logic d,
                       input logic [13:0] e, input string n);
        vec_t v;
        v.rst = r; v.instr = i; v.rdy = d; v.exp = e; v.name = n;
        vecs.push_back(v);
    endtask

    initial begin
        logic [13:0] act;

        add(1, I_ADD, 1, OZ, "reset0");
        add(1, I_ADD, 1, OZ, "reset1");
        add(0, I_ADD, 1, OF, "add_fetch");
        add(0, I_ADD, 1, OZ, "add_decode");
        add(0, I_ADD, 1, o(0,0,1,4'b0000,0,0,0,0,1,0,0), "add_exe");
        add(0, I_SUB, 1, OF, "sub_fetch");
        add(0, I_SUB, 1, OZ, "sub_decode");
        add(0, I_SUB, 1, o(0,0,1,4'b1000,0,0,0,0,1,0,0), "sub_exe");
        add(0, I_SRAI, 1, OF, "srai_fetch");
        add(0, I_SRAI, 1, OZ, "srai_decode");
        add(0, I_SRAI, 1, o(0,0,1,4'b1101,1,0,0,0,1,0,0), "srai_exe");
        add(0, I_ADDI, 1, OF, "addi_fetch");
        add(0, I_ADDI, 1, OZ, "addi_decode");
        add(0, I_ADDI, 1, o(0,0,1,4'b0000,1,0,0,0,1,0,0), "addi_exe");
        add(0, I_SW, 1, OF, "sw_fetch");
        add(0, I_SW, 1, OZ, "sw_decode");
        add(0, I_SW, 1, o(0,0,0,4'b0000,1,0,0,0,0,0,0), "sw_exe");
        add(0, I_SW, 1, o(0,0,0,4'b0000,0,0,1,0,1,0,0), "sw_mem");
        add(0, I_LW, 1, OF, "lw_fetch");
        add(0, I_LW, 1, OZ, "lw_decode");
        add(0, I_LW, 1, o(0,0,0,4'b0000,1,0,0,0,0,0,0), "lw_exe");
        add(0, I_LW, 1, o(0,0,0,4'b0000,0,0,0,1,0,0,0), "lw_mem");
        add(0, I_LW, 1, o(0,0,1,4'b0000,0,1,0,0,1,0,0), "lw_wb");
        add(0, I_BAD, 1, OF, "bad_fetch");
        add(0, I_BAD, 1, o(0,0,0,4'b0000,0,0,0,0,0,1,0), "bad_decode");
        add(0, I_ADD, 1, OF, "bad_next_fetch");
        add(0, I_ADD, 1, OZ, "bad_next_decode");
        add(0, I_ADD, 1, o(0,0,1,4'b0000,0,0,0,0,1,0,0), "bad_next_exe");
        add(0, I_LW, 0, OF, "lwr_fetch");
        add(0, I_LW, 0, OZ, "lwr_decode");
        add(0, I_LW, 0, o(0,0,0,4'b0000,1,0,0,0,0,0,0), "lwr_exe");
        add(1, I_LW, 0, OZ, "lwr_mem_reset");
        add(0, I_ADD, 1, OF, "lwr_after_fetch");
        add(0, I_ADD, 1, OZ, "lwr_after_decode");
        add(0, I_ADD, 1, o(0,0,1,4'b0000,0,0,0,0,1,0,0), "lwr_after_exe");
`ifdef CU_MEM_WAIT_EN
        add(0, I_LW, 0, OF, "lws_fetch");
        add(0, I_LW, 0, OZ, "lws_decode");
        add(0, I_LW, 0, o(0,0,0,4'b0000,1,0,0,0,0,0,0), "lws_exe");
        for (int k = 0; k < 3; k++)
            add(0, I_LW, 0, o(0,0,0,4'b0000,0,0,0,1,0,0,0), "lws_mem_wait");
        add(0, I_LW, 1, o(0,0,0,4'b0000,0,0,0,1,0,0,0), "lws_mem_done");
        add(0, I_LW, 1, o(0,0,1,4'b0000,0,1,0,0,1,0,0), "lws_wb");
        add(0, I_SW, 0, OF, "sws_fetch");
        add(0, I_SW, 0, OZ, "sws_decode");
        add(0, I_SW, 0, o(0,0,0,4'b0000,1,0,0,0,0,0,0), "sws_exe");
        add(0, I_SW, 0, o(0,0,0,4'b0000,0,0,1,0,0,0,0), "sws_mem_wait");
        add(0, I_SW, 1, o(0,0,0,4'b0000,0,0,1,0,1,0,0), "sws_mem_done");
        add(0, I_SW, 1, OF, "sws_next_fetch");
        add(0, I_SW, 1, OZ, "sws_next_decode");
        add(0, I_LW, 0, o(0,0,0,4'b0000,1,0,0,0,0,0,0), "lwt_exe");
        for (int k = 1; k < 15; k++)
            add(0, I_LW, 0, o(0,0,0,4'b0000,0,0,0,1,0,0,0), "lwt_mem_wait");
        add(0, I_LW, 0, o(0,0,0,4'b0000,0,0,0,1,0,0,1), "lwt_mem_timeout");
        add(0, I_LW, 0, OF, "lwt_next_fetch");
        add(0, I_LW, 0, OZ, "lwt_next_decode");
`else
        add(0, I_LW, 0, OF, "lwn_fetch");
        add(0, I_LW, 0, OZ, "lwn_decode");
        add(0, I_LW, 0, o(0,0,0,4'b0000,1,0,0,0,0,0,0), "lwn_exe");
        add(0, I_LW, 0, o(0,0,0,4'b0000,0,0,0,1,0,0,0), "lwn_mem");
        add(0, I_LW, 0, o(0,0,1,4'b0000,0,1,0,0,1,0,0), "lwn_wb");
        add(0, I_SW, 0, OF, "swn_fetch");
        add(0, I_SW, 0, OZ, "swn_decode");
        add(0, I_SW, 0, o(0,0,0,4'b0000,1,0,0,0,0,0,0), "swn_exe");
        add(0, I_SW, 0, o(0,0,0,4'b0000,0,0,1,0,1,0,0), "swn_mem");
        add(0, I_SW, 0, OF, "swn_next_fetch");
`endif

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            reset     = vecs[i].rst;
            instrCode = vecs[i].instr;
            dataReady = vecs[i].rdy;
            #1;
            act = {pcEn, irWe, regFileWe, aluControl, aluSrcMuxSel, wbSrcMuxSel,
                   dataWe, dataRe, instrRetire, illegalInstr, busErr};
            n_applied++;
            if (act !== vecs[i].exp) begin
                n_miscompares++;
                $display("FAIL %s (vec %0d): got %b expected %b", vecs[i].name, i, act, vecs[i].exp);
            end
            if (vecs[i].rst && (act !== OZ)) begin
                n_miscompares++;
                $display("FAIL reset state %s (vec %0d): outputs %b not all zero", vecs[i].name, i, act);
            end
            if (regFileWe && dataWe) begin
                n_miscompares++;
                $display("FAIL %s (vec %0d): regFileWe and dataWe both high", vecs[i].name, i);
            end
            if ((vecs[i].name == "lwt_mem_timeout") && ((busErr !== 1'b1) || (regFileWe !== 1'b0))) begin
                n_miscompares++;
                $display("FAIL expired wait (vec %0d): busErr=%b regFileWe=%b", i, busErr, regFileWe);
            end
            if ((vecs[i].name == "lwt_next_fetch") && ((pcEn !== 1'b1) || (irWe !== 1'b1))) begin
                n_miscompares++;
                $display("FAIL after timeout (vec %0d): not in FETCH, pcEn=%b irWe=%b", i, pcEn, irWe);
            end
        end

        if (n_miscompares != 0)
            $display("FAIL: %0d miscompares", n_miscompares);
        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule
